// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/video memory arbiter: FSM state encoding and access owner.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of video grants made while the CPU waits; at_limit flags the CPU's turn.
module starve_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] r_count;

  assign at_limit = (r_count == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU read/write, video read-only) arbiter onto a 1-cycle synchronous RAM.
// Macro MEM_ARBITER_STARVE_GUARD_EN enables the CPU starvation guard; otherwise video has strict priority.
//
//   state    | meaning
//   ST_IDLE  | no access; arbitrate and latch the winner
//   ST_ISSUE | address on RAM, ram_we high for a CPU write
//   ST_WAIT  | RAM read data valid; captured at end of cycle
//   ST_DONE  | owner's ack pulse
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  input  logic              vid_req,
  input  logic [DATA_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  logic              r_write;
  logic [DATA_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_vid_rdata;
  logic              w_idle;
  logic              w_grant_vid;
  logic              w_grant_cpu;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  assign w_idle = (r_state == ST_IDLE);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic w_at_limit;
  logic w_cnt_inc;
  logic w_cnt_clr;

  // The CPU wins a tie only once video has been granted STARVE_LIMIT times in a row.
  assign w_grant_vid = w_idle && vid_req && !(cpu_req && w_at_limit);
  assign w_grant_cpu = w_idle && cpu_req && !w_grant_vid;
  assign w_cnt_inc   = w_grant_vid && cpu_req;
  assign w_cnt_clr   = w_grant_cpu || (w_idle && !cpu_req);

  starve_counter #(
    .CNT_W(CNT_W)
  ) u_starve_counter (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_cnt_inc),
    .clr     (w_cnt_clr),
    .limit   (CNT_W'(STARVE_LIMIT)),
    .at_limit(w_at_limit)
  );
`else
  assign w_grant_vid = w_idle && vid_req;
  assign w_grant_cpu = w_idle && cpu_req && !vid_req;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant_vid || w_grant_cpu) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_CPU;
      r_write     <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
    end else begin
      if (w_grant_vid) begin
        r_owner     <= OWN_VID;
        r_write     <= 1'b0;
        r_ram_addr  <= vid_addr;
        r_ram_wdata <= '0;
      end else if (w_grant_cpu) begin
        r_owner     <= OWN_CPU;
        r_write     <= cpu_write;
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
      end
      // RAM data for the ISSUE address is valid during WAIT.
      if (r_state == ST_WAIT) begin
        if (r_owner == OWN_VID) begin
          r_vid_rdata <= ram_rdata;
        end else if (!r_write) begin
          r_cpu_rdata <= ram_rdata;
        end
      end
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = (r_state == ST_ISSUE) && r_write;
  assign cpu_rdata = r_cpu_rdata;
  assign vid_rdata = r_vid_rdata;
  assign cpu_ack   = (r_state == ST_DONE) && (r_owner == OWN_CPU);
  assign vid_ack   = (r_state == ST_DONE) && (r_owner == OWN_VID);
  assign cpu_busy  = !w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle synchronous RAM.
// Starvation expectations follow MEM_ARBITER_STARVE_GUARD_EN as the design is built.
module tb_mem_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_write;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_busy;
  logic          vid_req;
  logic [DW-1:0] vid_addr, vid_rdata;
  logic          vid_ack;
  logic [DW-1:0] ram_addr, ram_wdata, ram_rdata;
  logic          ram_we;

  logic [DW-1:0] mem [0:65535];

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic          write;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .DATA_W      (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_write(cpu_write),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_busy (cpu_busy),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_rdata(vid_rdata),
    .vid_ack  (vid_ack),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial begin
    int            kinds[$];
    int            exp_kind[6];
    logic          saw_ack;
    logic          saw_we;
    logic [DW-1:0] addr_seen;

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h2222;

    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 16'h4000, 16'h1234, 16'hBEEF};
    vecs[2] = '{1'b0, 16'h4000, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 16'h0020, 16'h5A5A, 16'h1234};
    vecs[4] = '{1'b0, 16'h0020, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};

    reset = 1'b1; cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_addr = 0;
    #2;
    chk("rst_busy", 32'(cpu_busy), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_acks", {30'd0, cpu_ack, vid_ack}, 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_vid_rdata", 32'(vid_rdata), 0);
    @(negedge clk); reset = 1'b0;

    saw_we = 0; saw_ack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      saw_we  = saw_we | ram_we | cpu_busy;
      saw_ack = saw_ack | cpu_ack | vid_ack;
    end
    chk("idle_no_activity", {30'd0, saw_we, saw_ack}, 0);

    // CPU-only accesses: cycle 0 request, ISSUE 1, WAIT 2, DONE 3.
    for (int v = 0; v < 6; v++) begin
      cpu_req = 1; cpu_write = vecs[v].write; cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      chk($sformatf("v%0d_c0_busy", v), 32'(cpu_busy), 0);
      @(negedge clk);
      chk($sformatf("v%0d_c1_we", v), 32'(ram_we), 32'(vecs[v].write));
      chk($sformatf("v%0d_c1_addr", v), 32'(ram_addr), 32'(vecs[v].addr));
      if (vecs[v].write) chk($sformatf("v%0d_c1_wdata", v), 32'(ram_wdata), 32'(vecs[v].wdata));
      chk($sformatf("v%0d_c1_busy", v), 32'(cpu_busy), 1);
      @(negedge clk);
      chk($sformatf("v%0d_c2_we_ack", v), {30'd0, ram_we, cpu_ack}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_c3_acks", v), {30'd0, cpu_ack, vid_ack}, 32'b10);
      chk($sformatf("v%0d_c3_rdata", v), 32'(cpu_rdata), 32'(vecs[v].exp_rdata));
      cpu_req = 0; cpu_write = 0;
      @(negedge clk);
      chk($sformatf("v%0d_c4_idle", v), {30'd0, cpu_busy, cpu_ack}, 0);
    end

    // Video read alone.
    vid_req = 1; vid_addr = 16'h0020;
    @(negedge clk);
    chk("vid_c1_addr_we", {15'd0, ram_we, ram_addr}, 32'h0000_0020);
    @(negedge clk); @(negedge clk);
    chk("vid_c3_acks", {30'd0, cpu_ack, vid_ack}, 32'b01);
    chk("vid_c3_rdata", 32'(vid_rdata), 32'h5A5A);
    chk("vid_c3_cpu_rdata_kept", 32'(cpu_rdata), 32'hBEEF);
    vid_req = 0;
    @(negedge clk);

    // Simultaneous requests: video first, CPU granted on the next IDLE.
    cpu_req = 1; cpu_addr = 16'h0020; vid_req = 1; vid_addr = 16'h4000;
    @(negedge clk);
    chk("sim_c1_addr", 32'(ram_addr), 32'h4000);
    @(negedge clk); @(negedge clk);
    chk("sim_c3_acks", {30'd0, cpu_ack, vid_ack}, 32'b01);
    chk("sim_c3_vid_rdata", 32'(vid_rdata), 32'h1234);
    vid_req = 0;
    @(negedge clk);
    chk("sim_c4_idle", 32'(cpu_busy), 0);
    @(negedge clk);
    chk("sim_c5_addr", 32'(ram_addr), 32'h0020);
    @(negedge clk); @(negedge clk);
    chk("sim_c7_acks", {30'd0, cpu_ack, vid_ack}, 32'b10);
    chk("sim_c7_cpu_rdata", 32'(cpu_rdata), 32'h5A5A);
    cpu_req = 0;
    @(negedge clk);

    // Address change after grant must not reach the RAM.
    cpu_req = 1; cpu_addr = 16'h0010;
    @(negedge clk);
    cpu_addr = 16'h0020;
    chk("addrchg_c1_addr", 32'(ram_addr), 32'h0010);
    @(negedge clk);
    chk("addrchg_c2_addr", 32'(ram_addr), 32'h0010);
    @(negedge clk);
    chk("addrchg_c3_ack_rdata", {15'd0, cpu_ack, cpu_rdata}, {15'd0, 1'b1, 16'hBEEF});
    cpu_req = 0;
    @(negedge clk);

    // Reset during WAIT of a CPU read abandons it.
    cpu_req = 1; cpu_addr = 16'h0010;
    @(negedge clk); @(negedge clk);
    chk("rstmid_pre_busy", 32'(cpu_busy), 1);
    reset = 1;
    #1;
    chk("rstmid_busy_we", {30'd0, cpu_busy, ram_we}, 0);
    chk("rstmid_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rstmid_ack", 32'(cpu_ack), 0);
    cpu_req = 0;
    @(negedge clk); reset = 0;
    saw_ack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      saw_ack = saw_ack | cpu_ack;
    end
    chk("rstmid_no_late_ack", 32'(saw_ack), 0);

    // Both requests held continuously for six accesses.
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    exp_kind = '{0, 0, 0, 0, 1, 0};
`else
    exp_kind = '{0, 0, 0, 0, 0, 0};
`endif
    cpu_req = 1; cpu_addr = 16'h0010; vid_req = 1; vid_addr = 16'h0020;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (vid_ack && cpu_ack) kinds.push_back(2);
      else if (vid_ack) kinds.push_back(0);
      else if (cpu_ack) kinds.push_back(1);
    end
    cpu_req = 0; vid_req = 0;
    chk("starve_ack_count", 32'(kinds.size()), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < kinds.size()) chk($sformatf("starve_ack%0d_kind", k), 32'(kinds[k]), 32'(exp_kind[k]));
      else chk($sformatf("starve_ack%0d_missing", k), 32'hFFFF_FFFF, 32'(exp_kind[k]));
    end
    @(negedge clk);
    chk("end_idle", 32'(cpu_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
